kuznechik_decoder: RTL and testbench

//  Iterative GOST R 34.12-2015 "Kuznechik" block decryptor; inverse of the pipelined encoder.

---
 rtl/kuznechik_decoder.sv | 151 +++++++++++++++
 tb/tb_kuznechik_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/kuznechik_decoder.sv
// kuznechik_decoder: iterative Kuznechik block decryptor with on-chip key expansion and key cache
module kuznechik_decoder #(
  parameter bit CACHE_KEY = 1'b1,
  parameter int L_STEPS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [255:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);
  localparam int LC = 16 / L_STEPS;
  localparam logic [3:0] LAST = 4'(LC - 1);
  localparam logic [2047:0] PI = {
    256'hfceedd11cf6e3116fbc4fada23c5044de977f0db932e99ba1736f1bb14cd5fc1,
    256'hf918655ae25cef21811c3c428b018e4f058402aee36a8fa0060bed987fd4d31f,
    256'heb342c51eac848abf22a68a2fd3aceccb5700e56080c7612bf7213479cb75d87,
    256'h15a19629107b9ac7f391786f9d9eb2b13275193dff358a7e6d54c680c3bd0d57,
    256'hdff524a93ea843c9d779d6f67c22b903e00fecde7a94b0bcdce828504e330a4a,
    256'ha79760731e0062441ab83882649f2641ad454692275e552f8ca3a57d69d5953b,
    256'h0758b34086ac1df730376be488d9e789e11b83494c3ff8fe8d53aa90cad88561,
    256'h207167a42d2b095bcb9b25d0bee56c5259a674d2e6f4b4c0d166afc2394b63b6};
  localparam logic [127:0] LCOEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
  function automatic logic [2047:0] inv_tab(input logic [2047:0] t);
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[2047 - 8 * int'(t[2047 - 8 * i -: 8]) -: 8] = 8'(i);
    return r;
  endfunction
  localparam logic [2047:0] PI_INV = inv_tab(PI);
  function automatic logic [127:0] sub(input logic [127:0] a, input logic [2047:0] t);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8 * i +: 8] = t[2047 - 8 * int'(a[8 * i +: 8]) -: 8];
    return r;
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, m;
    p = '0;
    m = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ m : p;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'hc3 : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] lin(input logic [127:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r ^= gmul(a[8 * i +: 8], LCOEF[8 * i +: 8]);
    return r;
  endfunction
  // L_STEPS forward (R) or inverse (R^-1) steps through the shared linear layer
  function automatic logic [127:0] lstep(input logic [127:0] a, input logic inv);
    logic [127:0] r;
    r = a;
    for (int i = 0; i < L_STEPS; i++)
      r = inv ? {r[119:0], lin({r[119:0], r[127:120]})} : {lin(r), r[127:8]};
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE, KEYGEN, DEC, DONE} state_t;
  state_t state, state_n;
  logic up, key_cached, hit, acc, last;
  logic [1:0] ph;
  logic [3:0] step;
  logic [5:0] rnd;
  logic [255:0] key_reg;
  logic [127:0] kr [10];
  logic [127:0] blk, x, a1, a0, lo;
  assign acc = in_valid && in_ready;
  assign hit = CACHE_KEY && key_cached && in_key == key_reg;
  assign last = step == LAST;
  assign lo = lstep(state == KEYGEN && ph == 2'd0 && step == 4'd0 ? {122'd0, rnd} : x, state == DEC);
  assign in_ready = up && state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_block = x;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (hit ? DEC : KEYGEN) : IDLE;
      KEYGEN:  state_n = ph == 2'd2 && last && rnd == 6'd32 ? DEC : KEYGEN;
      DEC:     state_n = ph == 2'd2 && rnd == 6'd1 ? DONE : DEC;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // KEYGEN phases: 0 = C_i, 1 = S, 2 = L and Feistel swap; DEC phases: 0 = K10 whitening, 1 = L^-1, 2 = S^-1 and K_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      up <= 1'b0;
      key_cached <= 1'b0;
      key_reg <= '0;
      for (int i = 0; i < 10; i++) kr[i] <= '0;
      blk <= '0;
      x <= '0;
      a1 <= '0;
      a0 <= '0;
      ph <= '0;
      step <= '0;
      rnd <= '0;
    end else begin
      state <= state_n;
      up <= 1'b1;
      case (state)
        IDLE: if (acc) begin
          blk <= in_block;
          ph <= 2'd0;
          step <= 4'd0;
          rnd <= hit ? 6'd9 : 6'd1;
          if (!hit) begin
            key_cached <= 1'b0;
            key_reg <= in_key;
            kr[0] <= in_key[255:128];
            kr[1] <= in_key[127:0];
            a1 <= in_key[255:128];
            a0 <= in_key[127:0];
          end
        end
        KEYGEN: begin
          step <= ph == 2'd1 || last ? 4'd0 : step + 4'd1;
          x <= ph == 2'd1 ? sub(a1 ^ x, PI) : lo;
          ph <= ph == 2'd1 ? 2'd2 : last ? (ph == 2'd0 ? 2'd1 : 2'd0) : ph;
          if (ph == 2'd2 && last) begin
            a1 <= lo ^ a0;
            a0 <= a1;
            rnd <= rnd == 6'd32 ? 6'd9 : rnd + 6'd1;
            if (rnd[2:0] == 3'd0) begin
              kr[{rnd[5:3], 1'b0}] <= lo ^ a0;
              kr[{rnd[5:3], 1'b1}] <= a1;
            end
            if (rnd == 6'd32) key_cached <= 1'b1;
          end
        end
        DEC: begin
          step <= ph == 2'd1 && !last ? step + 4'd1 : 4'd0;
          x <= ph == 2'd0 ? blk ^ kr[9] : ph == 2'd1 ? lo : sub(x, PI_INV) ^ kr[4'(rnd - 6'd1)];
          ph <= ph == 2'd1 && last ? 2'd2 : 2'd1;
          if (ph == 2'd2) rnd <= rnd - 6'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kuznechik_decoder.sv
// tb_kuznechik_decoder: GOST vector, cache, backpressure, reset and random round-trip checks
module tb_kuznechik_decoder;
  localparam logic [2047:0] PI = {
    256'hfceedd11cf6e3116fbc4fada23c5044de977f0db932e99ba1736f1bb14cd5fc1,
    256'hf918655ae25cef21811c3c428b018e4f058402aee36a8fa0060bed987fd4d31f,
    256'heb342c51eac848abf22a68a2fd3aceccb5700e56080c7612bf7213479cb75d87,
    256'h15a19629107b9ac7f391786f9d9eb2b13275193dff358a7e6d54c680c3bd0d57,
    256'hdff524a93ea843c9d779d6f67c22b903e00fecde7a94b0bcdce828504e330a4a,
    256'ha79760731e0062441ab83882649f2641ad454692275e552f8ca3a57d69d5953b,
    256'h0758b34086ac1df730376be488d9e789e11b83494c3ff8fe8d53aa90cad88561,
    256'h207167a42d2b095bcb9b25d0bee56c5259a674d2e6f4b4c0d166afc2394b63b6};
  localparam logic [255:0] K1 = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] C1 = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] P1 = 128'h1122334455667700ffeeddccbbaa9988;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] iv = '0, ordy = '0, ir, ov, bz;
  logic [2:0][127:0] ib = '0, ob;
  logic [2:0][255:0] ik = '0;
  int lcs [3] = '{16, 4, 1};
  int coef [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
  bit cached [3];
  logic [255:0] last_key [3];
  logic [7:0] pi_t [256], pi_i [256];
  logic [127:0] mk [10];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    kuznechik_decoder #(.CACHE_KEY(g != 2), .L_STEPS(g == 0 ? 1 : g == 1 ? 4 : 16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_block(ib[g]),
      .in_key(ik[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .out_block(ob[g]), .busy(bz[g]));
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int gf(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p ^= a << i;
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) == 1) p ^= 'h1c3 << (i - 8);
    return p;
  endfunction
  function automatic int lsum(input logic [127:0] v);
    int s = 0;
    for (int k = 0; k < 16; k++) s ^= gf(int'(v[127 - 8 * k -: 8]), coef[k]);
    return s;
  endfunction
  function automatic logic [127:0] lin(input logic [127:0] v, input bit inv);
    for (int i = 0; i < 16; i++)
      v = inv ? {v[119:0], 8'(lsum({v[119:0], v[127:120]}))} : {8'(lsum(v)), v[127:8]};
    return v;
  endfunction
  function automatic logic [127:0] sbox(input logic [127:0] v, input bit inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = inv ? pi_i[v[127 - 8 * k -: 8]] : pi_t[v[127 - 8 * k -: 8]];
    return r;
  endfunction
  task automatic expand(input logic [255:0] key);
    logic [127:0] a1, a0, t;
    a1 = key[255:128];
    a0 = key[127:0];
    mk[0] = a1;
    mk[1] = a0;
    for (int i = 1; i <= 32; i++) begin
      t = lin(sbox(a1 ^ lin(128'(i), 1'b0), 1'b0), 1'b0) ^ a0;
      a0 = a1;
      a1 = t;
      if (i % 8 == 0) begin
        mk[i / 4] = a1;
        mk[i / 4 + 1] = a0;
      end
    end
  endtask
  function automatic logic [127:0] enc(input logic [127:0] p);
    for (int i = 0; i < 9; i++) p = lin(sbox(p ^ mk[i], 1'b0), 1'b0);
    return p ^ mk[9];
  endfunction
  function automatic logic [127:0] dec(input logic [127:0] c);
    c = c ^ mk[9];
    for (int i = 8; i >= 0; i--) c = sbox(lin(c, 1'b1), 1'b1) ^ mk[i];
    return c;
  endfunction
  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk({tag, " rst out_valid"}, 128'(ov[k]), 128'd0);
      chk({tag, " rst busy"}, 128'(bz[k]), 128'd0);
      chk({tag, " rst in_ready"}, 128'(ir[k]), 128'd0);
      chk({tag, " rst out_block"}, ob[k], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk({tag, " post-rst in_ready"}, 128'(ir[k]), 128'd1);
      cached[k] = 1'b0;
    end
  endtask
  task automatic start(input int k, input logic [127:0] c, input logic [255:0] key);
    @(negedge clk);
    ib[k] = c;
    ik[k] = key;
    iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
  endtask
  task automatic xfer(input int k, input logic [127:0] c, input logic [255:0] key, input logic [127:0] p,
                      input int hold, input bit early, input string tag);
    int n, lat;
    lat = (k == 2 || !cached[k] || last_key[k] != key ? 32 * (2 * lcs[k] + 1) : 0) + 1 + 9 * (lcs[k] + 1);
    cached[k] = 1'b1;
    last_key[k] = key;
    @(negedge clk);
    chk({tag, " in_ready"}, 128'(ir[k]), 128'd1);
    ib[k] = c;
    ik[k] = key;
    iv[k] = 1'b1;
    ordy[k] = early;
    @(posedge clk);
    #1 iv[k] = 1'b0;
    n = 0;
    while (!ov[k] && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'(lat));
    chk({tag, " plaintext"}, ob[k], p);
    for (int i = 0; i < hold; i++) begin
      iv[k] = i[0];
      ib[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      chk({tag, " held block"}, ob[k], p);
      chk({tag, " held valid/ready"}, 128'({ov[k], ir[k]}), 128'd2);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk);
    #1 ordy[k] = 1'b0;
    chk({tag, " release valid/ready"}, 128'({ov[k], ir[k]}), 128'd1);
  endtask
  initial begin
    logic [255:0] key;
    logic [127:0] p;
    for (int i = 0; i < 256; i++) pi_t[i] = PI[2047 - 8 * i -: 8];
    for (int i = 0; i < 256; i++) pi_i[pi_t[i]] = 8'(i);
    reset_dut("init");
    for (int k = 0; k < 3; k++) xfer(k, C1, K1, P1, 0, 1'b0, "T1");
    xfer(0, C1, K1, P1, 0, 1'b0, "T2 cached");
    xfer(2, C1, K1, P1, 0, 1'b0, "T2 nocache");
    xfer(0, C1, K1, P1, 50, 1'b0, "T3");
    start(0, C1, K1 ^ 256'd1);
    repeat (499) @(posedge clk);
    #1 chk("T4 busy in keygen", 128'(bz[0]), 128'd1);
    reset_dut("T4 keygen");
    start(0, C1, K1);
    repeat (1056 + 77) @(posedge clk);
    #1 chk("T4 busy in dec", 128'(bz[0]), 128'd1);
    reset_dut("T4 dec");
    xfer(0, C1, K1, P1, 0, 1'b0, "T4 rerun");
    expand(K1 ^ 256'd1);
    xfer(0, C1, K1 ^ 256'd1, dec(C1), 0, 1'b0, "T6");
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < (k == 0 ? 6 : 12); n++) begin
        if (n % (k == 0 ? 2 : 3) == 0)
          for (int j = 0; j < 8; j++) key[32 * j +: 32] = $urandom();
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand(key);
        xfer(k, enc(p), key, p, 0, k == 1 && n % 3 == 1, "T5");
      end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
